// File: rtl/kronos_pkg.sv
// kronos_pkg: shared state encoding and word addresses for the kronos counter port.
package kronos_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, WRITE, RESP} state_t;
  localparam logic [1:0] CNT_ADDR_LO = 2'd0;
  localparam logic [1:0] CNT_ADDR_HI = 2'd1;
endpackage

// File: rtl/kronos_counter_port.sv
// kronos_counter_port: CSR access port for a staggered 64b counter; KRONOS_COUNTER_SNAPSHOT_EN adds a coherent lo/hi snapshot.
module kronos_counter_port
  import kronos_pkg::*;
#(
  parameter int EN_COUNTERS64B = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_wr,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_vld,
  input  logic        resp_rdy,
  output logic [31:0] resp_data,
  output logic        resp_err,
  input  logic [63:0] count,
  input  logic        count_vld,
  output logic [31:0] load_data,
  output logic        load_low,
  output logic        load_high
);
  state_t      state;
  logic        wr_q;
  logic [1:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] hi_word, rd_word;
`ifdef KRONOS_COUNTER_SNAPSHOT_EN
  logic [32:0] shadow;
  always_ff @(posedge clk)
    if (rst) shadow <= '0;
    else if (state == IDLE && req_vld && req_rdy && req_wr) shadow[32] <= 1'b0;
    else if (state == WAIT && count_vld && !wr_q && addr_q == CNT_ADDR_LO) shadow <= {1'b1, count[63:32]};
    else if (state == WAIT && count_vld && !wr_q && addr_q == CNT_ADDR_HI) shadow[32] <= 1'b0;
  always_comb hi_word = shadow[32] ? shadow[31:0] : count[63:32];
`else
  always_comb hi_word = count[63:32];
`endif
  always_comb rd_word = addr_q == CNT_ADDR_LO ? count[31:0] : (EN_COUNTERS64B != 0 ? hi_word : 32'h0);
  // strobes are registered so they land only in the single WRITE cycle after count_vld was seen
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_rdy   <= 1'b0;
      resp_vld  <= 1'b0;
      resp_err  <= 1'b0;
      resp_data <= '0;
      load_data <= '0;
      load_low  <= 1'b0;
      load_high <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      load_low  <= 1'b0;
      load_high <= 1'b0;
      case (state)
        IDLE: begin
          req_rdy <= 1'b1;
          if (req_vld && req_rdy) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            req_rdy <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (addr_q[1]) begin
            resp_vld <= 1'b1;
            resp_err <= 1'b1;
            state    <= RESP;
          end else if (count_vld && wr_q) begin
            load_data <= wdata_q;
            load_low  <= addr_q == CNT_ADDR_LO;
            load_high <= addr_q == CNT_ADDR_HI && EN_COUNTERS64B != 0;
            state     <= WRITE;
          end else if (count_vld) begin
            resp_vld  <= 1'b1;
            resp_data <= rd_word;
            state     <= RESP;
          end
        end
        WRITE: begin
          resp_vld <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (resp_rdy) begin
            resp_vld  <= 1'b0;
            resp_err  <= 1'b0;
            resp_data <= '0;
            req_rdy   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
